divide_seq: RTL and testbench

DIVIDE_SEQ -- requirements
Module: divide_seq

---
 rtl/div_pkg.sv | 14 +
 rtl/div_step.sv | 26 ++
 rtl/divide_seq.sv | 144 ++++++++++++++
 tb/tb_divide_seq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        ADJ  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on a {rem,quo} pair.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // The trial difference is only kept when it is below divisor, so the
    // low WIDTH bits of the subtraction are sufficient.
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        fits     = (shifted >= {1'b0, divisor});
        diff     = shifted[WIDTH-1:0] - divisor;
        rem_next = fits ? diff : shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/divide_seq.sv
// Sequential restoring divider, one quotient bit per cycle, fixed latency.
// Signed (DIV) support is compiled in only when DIVIDE_SIGNED_EN is defined.
module divide_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_t       state, state_d;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [WIDTH-1:0] rem_next, quo_next;
    logic [WIDTH-1:0] dvd_abs, dvs_abs;
    logic [WIDTH-1:0] quo_adj, rem_adj;

`ifdef DIVIDE_SIGNED_EN
    logic dvd_neg, dvs_neg;
    logic neg_quo, neg_rem;

    always_comb begin
        dvd_neg = is_signed & dividend[WIDTH-1];
        dvs_neg = is_signed & divisor[WIDTH-1];
        dvd_abs = dvd_neg ? ('0 - dividend) : dividend;
        dvs_abs = dvs_neg ? ('0 - divisor) : divisor;
        quo_adj = neg_quo ? ('0 - quo_q) : quo_q;
        rem_adj = neg_rem ? ('0 - rem_q) : rem_q;
    end

    // A zero divisor must leave the all-ones quotient unnegated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
        end else if (state == IDLE && start) begin
            neg_quo <= (dvd_neg ^ dvs_neg) & (divisor != '0);
            neg_rem <= dvd_neg;
        end
    end
`else
    logic unused_is_signed;

    always_comb begin
        unused_is_signed = is_signed;
        dvd_abs          = dividend;
        dvs_abs          = divisor;
        quo_adj          = quo_q;
        rem_adj          = rem_q;
    end
`endif

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvs_q),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    state_d = ADJ;
                end
            end
            ADJ: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cnt   <= CNT_W'(WIDTH - 1);
                        rem_q <= '0;
                        quo_q <= dvd_abs;
                        dvs_q <= dvs_abs;
                    end
                end
                CALC: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ADJ: begin
                    quotient  <= quo_adj;
                    remainder <= rem_adj;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divide_seq.sv
// Directed self-checking bench for divide_seq (WIDTH=32).
// Signed expectations are selected by DIVIDE_SIGNED_EN to match the build.
module tb_divide_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int checks = 0;
    int fails  = 0;

    divide_seq #(
        .WIDTH(32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start     = 1'b1;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Cycle i is the cycle after edge N+i, where N is the accepting edge.
    // poke >= 0 raises a stray start (9/3) at that cycle to test it is ignored.
    task automatic await_done(input string tag, input logic [31:0] eq,
                              input logic [31:0] er, input int poke);
        int   lat     = -1;
        logic busy_ok = 1'b1;
        logic busy_at = 1'b1;
        for (int i = 0; i <= 40; i++) begin
            @(negedge clk);
            if (i == poke) begin
                start    = 1'b1;
                dividend = 32'd9;
                divisor  = 32'd3;
            end else if (i == poke + 1) begin
                start = 1'b0;
            end
            if (done) begin
                lat     = i;
                busy_at = busy;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        start = 1'b0;
        check({tag, ".latency"}, 32'(lat), 32'd33);
        check({tag, ".busy_run"}, {31'd0, busy_ok}, 32'd1);
        check({tag, ".busy_at_done"}, {31'd0, busy_at}, 32'd0);
        check({tag, ".quotient"}, quotient, eq);
        check({tag, ".remainder"}, remainder, er);
    endtask

    initial begin
        logic seen_done;
        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        check("reset.busy", {31'd0, busy}, 32'd0);
        check("reset.done", {31'd0, done}, 32'd0);
        check("reset.quotient", quotient, 32'd0);
        check("reset.remainder", remainder, 32'd0);
        rst = 1'b0;

        issue(1'b0, 32'd100, 32'd7);
        await_done("u100_7", 32'd14, 32'd2, -1);

        issue(1'b0, 32'hFFFF_FFFF, 32'd2);
        await_done("uffff_2", 32'h7FFF_FFFF, 32'd1, -1);

        issue(1'b0, 32'd5, 32'd0);
        await_done("u5_0", 32'hFFFF_FFFF, 32'd5, -1);

`ifdef DIVIDE_SIGNED_EN
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        await_done("s-7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, -1);

        issue(1'b1, 32'd5, 32'd0);
        await_done("s5_0", 32'hFFFF_FFFF, 32'd5, -1);

        issue(1'b1, 32'hFFFF_FFF9, 32'd0);
        await_done("s-7_0", 32'hFFFF_FFFF, 32'hFFFF_FFF9, -1);

        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        await_done("s_ovf", 32'h8000_0000, 32'd0, -1);

        issue(1'b1, 32'd7, 32'hFFFF_FFFE);
        await_done("s7_-2", 32'hFFFF_FFFD, 32'd1, -1);
`else
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        await_done("nosign_fff9_2", 32'h7FFF_FFFC, 32'd1, -1);

        issue(1'b1, 32'd5, 32'd0);
        await_done("nosign5_0", 32'hFFFF_FFFF, 32'd5, -1);

        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        await_done("nosign_ovf", 32'd0, 32'h8000_0000, -1);
`endif

        // Stray start mid-operation, then start held across DONE into IDLE.
        issue(1'b0, 32'd100, 32'd7);
        await_done("ignore", 32'd14, 32'd2, 10);
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd9;
        divisor   = 32'd3;
        @(posedge clk);
        @(negedge clk);
        check("b2b.idle_after_done", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 start = 1'b0;
        await_done("b2b", 32'd3, 32'd0, -1);

        // Reset 15 cycles into an operation.
        issue(1'b0, 32'd1000, 32'd33);
        repeat (15) @(negedge clk);
        check("pre_rst.busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.done", {31'd0, done}, 32'd0);
        check("rst.quotient", quotient, 32'd0);
        check("rst.remainder", remainder, 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        check("rst.no_done", {31'd0, seen_done}, 32'd0);
        issue(1'b0, 32'd1000, 32'd33);
        await_done("after_rst", 32'd30, 32'd10, -1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

endmodule
